// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, NOP encoding, opcodes and fetch FSM states.
package cpu_pkg;
  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;
  localparam logic [15:0] NOP_WORD = 16'h0000;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SL  = 4'b0110;
  localparam logic [3:0] OP_BZ  = 4'b1100;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_BUBBLE = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. bubble overrides load; neither asserted holds contents.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int                 PC_W_P    = PC_W,
  parameter int                 INSTR_W_P = INSTR_W,
  parameter logic [INSTR_W_P-1:0] NOP_P   = NOP_WORD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 bubble,
  input  logic [INSTR_W_P-1:0] instr_in,
  input  logic [PC_W_P-1:0]    pc1_in,
  output logic [INSTR_W_P-1:0] instr_out,
  output logic [PC_W_P-1:0]    pc1_out,
  output logic                 valid_out
);
  logic [INSTR_W_P-1:0] instr_q, instr_d;
  logic [PC_W_P-1:0]    pc1_q, pc1_d;
  logic                 valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc1_d   = pc1_q;
    valid_d = valid_q;
    if (bubble) begin
      instr_d = NOP_P;
      pc1_d   = '0;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = instr_in;
      pc1_d   = pc1_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP_P;
      pc1_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc1_q   <= pc1_d;
      valid_q <= valid_d;
    end
  end

  assign instr_out = instr_q;
  assign pc1_out   = pc1_q;
  assign valid_out = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// PC generator, fetch FSM (BOOT/RUN/BUBBLE) and IF/ID register.
// Optional delivery/bubble counters enabled with macro FETCH_STATS_EN.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                 PC_W_P      = PC_W,
  parameter int                 INSTR_W_P   = INSTR_W,
  parameter int                 FLUSH_DEPTH = 1,
  parameter logic [INSTR_W_P-1:0] NOP_P     = NOP_WORD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 br_taken,
  input  logic [PC_W_P-1:0]    br_target,
  output logic [PC_W_P-1:0]    pc_out,
  input  logic [INSTR_W_P-1:0] instr_in,
  output logic [INSTR_W_P-1:0] if_id_instr,
  output logic [PC_W_P-1:0]    if_id_pc1,
  output logic                 if_id_valid
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]          fetch_cnt,
  output logic [15:0]          flush_cnt
`endif
);
  // bcnt holds the bubble cycles still to be spent in BUBBLE after the redirect cycle
  localparam logic [1:0] BCNT_INIT = 2'(FLUSH_DEPTH - 1);

  logic [PC_W_P-1:0] pc_q, pc_d, pc_inc;
  fetch_state_t      state_q, state_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic              ld, bub;

  assign pc_inc = pc_q + PC_W_P'(1);

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    bcnt_d  = bcnt_q;
    ld      = 1'b0;
    bub     = 1'b0;
    case (state_q)
      ST_BOOT: begin
        bub     = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN, ST_BUBBLE: begin
        if (br_taken) begin
          pc_d    = br_target;
          bub     = 1'b1;
          bcnt_d  = BCNT_INIT;
          state_d = (FLUSH_DEPTH > 1) ? ST_BUBBLE : ST_RUN;
        end else if (state_q == ST_BUBBLE) begin
          bub    = 1'b1;
          bcnt_d = bcnt_q - 2'd1;
          if (bcnt_q == 2'd1) state_d = ST_RUN;
        end else if (!stall) begin
          ld   = 1'b1;
          pc_d = pc_inc;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      state_q <= ST_BOOT;
      bcnt_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign pc_out = pc_q;

  if_id_reg #(
    .PC_W_P    (PC_W_P),
    .INSTR_W_P (INSTR_W_P),
    .NOP_P     (NOP_P)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .load      (ld),
    .bubble    (bub),
    .instr_in  (instr_in),
    .pc1_in    (pc_inc),
    .instr_out (if_id_instr),
    .pc1_out   (if_id_pc1),
    .valid_out (if_id_valid)
  );

`ifdef FETCH_STATS_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // the BOOT bubble is not a redirect bubble and is not counted
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (ld && fetch_cnt_q != 16'hFFFF) fetch_cnt_d = fetch_cnt_q + 16'd1;
    if (bub && state_q != ST_BOOT && flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a cycle-level behavioural model.
module tb_fetch_stage;
  localparam int FD = 2;
  localparam logic [15:0] NOP = 16'h0000;

  logic        clk = 1'b0;
  logic        rst, stall, br_taken;
  logic [15:0] br_target, pc_out, instr_in, if_id_instr, if_id_pc1;
  logic        if_id_valid;
`ifdef FETCH_STATS_EN
  logic [15:0] fetch_cnt, flush_cnt;
`endif

  logic [15:0] mem [256];
  assign instr_in = mem[pc_out[7:0]];

  always #5 clk = ~clk;

  fetch_stage #(.FLUSH_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .pc_out(pc_out), .instr_in(instr_in), .if_id_instr(if_id_instr),
    .if_id_pc1(if_id_pc1), .if_id_valid(if_id_valid)
`ifdef FETCH_STATS_EN
    , .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: architectural view of fetch
  logic [15:0] m_pc, m_instr, m_pc1;
  logic        m_valid, m_boot;
  int          m_left;
  int          m_fc, m_flc;

  task automatic cycle(input logic r, input logic s, input logic b, input logic [15:0] t);
    rst = r; stall = s; br_taken = b; br_target = t;
    @(posedge clk);
    if (r) begin
      m_pc = 0; m_instr = NOP; m_pc1 = 0; m_valid = 0; m_boot = 1; m_left = 0;
      m_fc = 0; m_flc = 0;
    end else if (m_boot) begin
      m_instr = NOP; m_valid = 0; m_boot = 0;
    end else if (b) begin
      m_pc = t; m_instr = NOP; m_valid = 0; m_left = FD - 1;
      if (m_flc < 65535) m_flc++;
    end else if (m_left > 0) begin
      m_instr = NOP; m_valid = 0; m_left--;
      if (m_flc < 65535) m_flc++;
    end else if (!s) begin
      m_instr = mem[m_pc[7:0]]; m_pc1 = m_pc + 16'd1; m_valid = 1; m_pc = m_pc + 16'd1;
      if (m_fc < 65535) m_fc++;
    end
    #1;
    chk("pc_out", pc_out, m_pc);
    chk("valid", if_id_valid, m_valid);
    chk("instr", if_id_instr, m_instr);
    if (m_valid) chk("pc1", if_id_pc1, m_pc1);
`ifdef FETCH_STATS_EN
    chk("fetch_cnt", fetch_cnt, m_fc);
    chk("flush_cnt", flush_cnt, m_flc);
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    rst = 1; stall = 0; br_taken = 0; br_target = 0;

    // reset then free run
    cycle(1, 0, 0, 0);
    chk("rst_pc1", if_id_pc1, 0);
    chk("rst_instr", if_id_instr, NOP);
    cycle(0, 0, 0, 0);
    chk("boot_pc", pc_out, 0);
    cycle(0, 0, 0, 0);
    chk("first_instr", if_id_instr, mem[0]);
    chk("first_pc1", if_id_pc1, 16'd1);
    chk("first_valid", if_id_valid, 1);
    cycle(0, 0, 0, 0);
    // stall three cycles at pc=2
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 0);
      chk("stall_pc", pc_out, 16'd2);
      chk("stall_pc1", if_id_pc1, 16'd2);
    end
    cycle(0, 0, 0, 0);
    chk("adv_pc", pc_out, 16'd3);
    cycle(0, 0, 0, 0);
    // redirect to 6 at pc=4
    cycle(0, 0, 1, 16'd6);
    chk("br_pc", pc_out, 16'd6);
    chk("br_valid", if_id_valid, 0);
    for (int i = 0; i < FD - 1; i++) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("br_instr", if_id_instr, mem[6]);
    // redirect beats stall
    cycle(0, 1, 1, 16'd1);
    chk("brst_pc", pc_out, 16'd1);
    chk("brst_valid", if_id_valid, 0);
    for (int i = 0; i < FD - 1; i++) cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    // wrap at FFFF
    cycle(0, 0, 1, 16'hFFFF);
    for (int i = 0; i < FD - 1; i++) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("wrap_pc", pc_out, 16'd0);
    chk("wrap_pc1", if_id_pc1, 16'd0);
    chk("wrap_instr", if_id_instr, mem[255]);

`ifdef FETCH_STATS_EN
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 16'd40);
    for (int i = 0; i < FD - 1; i++) cycle(0, 0, 0, 0);
    chk("stat_fetch", fetch_cnt, 16'd8);
    chk("stat_flush", flush_cnt, FD);
    cycle(0, 0, 1, 16'd50);
    cycle(1, 0, 0, 0);
    chk("stat_rst_f", fetch_cnt, 0);
    chk("stat_rst_b", flush_cnt, 0);
`endif

    // mid-bubble reset
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 16'd77);
    cycle(1, 0, 0, 0);
    chk("rstbub_pc", pc_out, 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic r, s, b;
      logic [15:0] t;
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 7) == 0);
      t = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom);
      cycle(r, s, b, t);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
